// File: rtl/exc_unit.sv
// Exception arbitration and timed flush sequencer at the MEM/WB boundary.
// Optional macro EXC_CP0_FWD_EN: forward in-flight WB CP0 writes (Status, Cause[9:8], EPC).
module exc_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] cur_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [4:0]  exc_flags_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cur_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    localparam logic [31:0] EXC_NONE    = 32'h0;
    localparam logic [31:0] EXC_INT     = 32'h1;
    localparam logic [31:0] EXC_SYSCALL = 32'h8;
    localparam logic [31:0] EXC_INVALID = 32'hA;
    localparam logic [31:0] EXC_TRAP    = 32'hD;
    localparam logic [31:0] EXC_OVF     = 32'hC;
    localparam logic [31:0] EXC_ERET    = 32'hE;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        st;
    logic [31:0]        ca;
    logic [31:0]        ep;
    logic               int_req;
    logic [31:0]        exc_type;

`ifdef EXC_CP0_FWD_EN
    // Effective CP0 view including the write currently retiring in WB
    always_comb begin
        st = cp0_status_i;
        ca = cp0_cause_i;
        ep = cp0_epc_i;
        if (wb_cp0_we_i && (wb_cp0_waddr_i == ADDR_STATUS)) begin
            st = wb_cp0_data_i;
        end
        if (wb_cp0_we_i && (wb_cp0_waddr_i == ADDR_CAUSE)) begin
            ca[9:8] = wb_cp0_data_i[9:8];
        end
        if (wb_cp0_we_i && (wb_cp0_waddr_i == ADDR_EPC)) begin
            ep = wb_cp0_data_i;
        end
    end
`else
    always_comb begin
        st = cp0_status_i;
        ca = cp0_cause_i;
        ep = cp0_epc_i;
    end

    wire unused_wb = &{1'b0, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i};
`endif

    wire unused_bits = &{1'b0, st[31:16], st[7:2], ca[31:16], ca[7:0]};

    assign int_req = st[0] & ~st[1] & (|(ca[15:8] & st[15:8]));

    // Priority encoder, live only in IDLE with a real instruction
    always_comb begin
        exc_type = EXC_NONE;
        if (!rst && (state == IDLE) && inst_valid_i) begin
            if (int_req)             exc_type = EXC_INT;
            else if (exc_flags_i[0]) exc_type = EXC_SYSCALL;
            else if (exc_flags_i[1]) exc_type = EXC_INVALID;
            else if (exc_flags_i[2]) exc_type = EXC_TRAP;
            else if (exc_flags_i[3]) exc_type = EXC_OVF;
            else if (exc_flags_i[4]) exc_type = EXC_ERET;
        end
    end

    assign excepttype_o      = exc_type;
    assign cur_inst_addr_o   = cur_inst_addr_i;
    assign is_in_delayslot_o = is_in_delayslot_i;

    // Flush sequencer; new_pc_o holds after the flush ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            flush_o  <= 1'b0;
            new_pc_o <= 32'h0;
        end else if (state == IDLE) begin
            if (exc_type != EXC_NONE) begin
                new_pc_o <= (exc_type == EXC_ERET) ? ep : EXC_VECTOR;
                cnt      <= CNT_W'(FLUSH_CYCLES - 1);
                flush_o  <= 1'b1;
                state    <= FLUSH;
            end
        end else begin
            if (cnt == '0) begin
                flush_o <= 1'b0;
                state   <= IDLE;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exc_unit.sv
// Scoreboard bench for exc_unit: per-cycle expectations from a behavioural model.
module tb_exc_unit;

    localparam int unsigned FC = 3;
    localparam logic [31:0] VEC = 32'h0000_0020;
`ifdef EXC_CP0_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid_i = 1'b0;
    logic [31:0] cur_inst_addr_i = '0;
    logic        is_in_delayslot_i = 1'b0;
    logic [4:0]  exc_flags_i = '0;
    logic [31:0] cp0_status_i = '0;
    logic [31:0] cp0_cause_i = '0;
    logic [31:0] cp0_epc_i = '0;
    logic        wb_cp0_we_i = 1'b0;
    logic [4:0]  wb_cp0_waddr_i = '0;
    logic [31:0] wb_cp0_data_i = '0;
    logic [31:0] excepttype_o;
    logic [31:0] cur_inst_addr_o;
    logic        is_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    exc_unit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .cur_inst_addr_i(cur_inst_addr_i),
        .is_in_delayslot_i(is_in_delayslot_i), .exc_flags_i(exc_flags_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .excepttype_o(excepttype_o), .cur_inst_addr_o(cur_inst_addr_o),
        .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exc;
        logic [31:0] addr;
        logic        ds;
        logic        fl;
        logic [31:0] npc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;
    int   n_push  = 0;
    int   n_pop   = 0;

    // Model state: flush cycles still owed, and the PC last handed out
    int          rem = 0;
    logic [31:0] mpc = 32'h0;

    function automatic logic [31:0] ref_exc(input bit v, input logic [4:0] fl,
                                            input logic [31:0] s, input logic [31:0] c,
                                            input bit we, input logic [4:0] wa,
                                            input logic [31:0] wd);
        logic [31:0] s_eff;
        logic [7:0]  ip;
        if (!v) return 32'h0;
        s_eff = (FWD && we && wa == 5'd12) ? wd : s;
        ip = c[15:8];
        if (FWD && we && wa == 5'd13) ip[1:0] = wd[9:8];
        if (s_eff[0] && !s_eff[1] && ((ip & s_eff[15:8]) != 8'h0)) return 32'h1;
        if (fl[0]) return 32'h8;
        if (fl[1]) return 32'hA;
        if (fl[2]) return 32'hD;
        if (fl[3]) return 32'hC;
        if (fl[4]) return 32'hE;
        return 32'h0;
    endfunction

    task automatic cyc(input bit r, input bit v, input logic [31:0] pc, input bit ds,
                       input logic [4:0] fl, input logic [31:0] s, input logic [31:0] c,
                       input logic [31:0] e, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; inst_valid_i = v; cur_inst_addr_i = pc; is_in_delayslot_i = ds;
        exc_flags_i = fl; cp0_status_i = s; cp0_cause_i = c; cp0_epc_i = e;
        wb_cp0_we_i = we; wb_cp0_waddr_i = wa; wb_cp0_data_i = wd;
        n_cyc++;
        x.addr = pc; x.ds = ds; x.cyc = n_cyc;
        if (r) begin
            rem = 0; mpc = 32'h0;
            x.exc = 32'h0; x.fl = 1'b0; x.npc = 32'h0;
        end else if (rem > 0) begin
            x.exc = 32'h0; x.fl = 1'b1; x.npc = mpc;
            rem--;
        end else begin
            x.fl = 1'b0; x.npc = mpc;
            x.exc = ref_exc(v, fl, s, c, we, wa, wd);
            if (x.exc != 32'h0) begin
                rem = FC;
                mpc = (x.exc == 32'hE) ? ((FWD && we && wa == 5'd14) ? wd : e) : VEC;
            end
        end
        sb.push_back(x);
        n_push++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 5'h0, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
    endtask

    task automatic chk(input string name, input int cy, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cy, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            n_pop++;
            chk("excepttype", x.cyc, excepttype_o, x.exc);
            chk("cur_inst_addr", x.cyc, cur_inst_addr_o, x.addr);
            chk("delayslot", x.cyc, 32'(is_in_delayslot_o), 32'(x.ds));
            chk("flush", x.cyc, 32'(flush_o), 32'(x.fl));
            chk("new_pc", x.cyc, new_pc_o, x.npc);
        end
    end

    initial begin
        logic [31:0] s, c, pc;
        logic [4:0]  fl, wa;
        int          k;
        // reset state
        cyc(1, 0, 32'h0, 0, 5'h0, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
        cyc(1, 1, 32'h44, 1, 5'h1, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
        idle(1);
        // syscall then 3-cycle flush to the vector
        cyc(0, 1, 32'h100, 0, 5'b00001, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
        idle(4);
        // invalid + overflow -> invalid
        cyc(0, 1, 32'h104, 1, 5'b01010, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
        idle(4);
        // interrupt beats syscall
        cyc(0, 1, 32'h108, 0, 5'b00001, 32'h0000_FF01, 32'h0000_0400, 32'h0, 0, 5'h0, 32'h0);
        idle(4);
        // eret with EPC write retiring in WB
        cyc(0, 1, 32'h10C, 0, 5'b10000, 32'h0, 32'h0, 32'h400, 1, 5'd14, 32'h800);
        idle(4);
        // interrupt and eret together: interrupt wins, vector target
        cyc(0, 1, 32'h110, 0, 5'b10000, 32'h0000_FF01, 32'h0000_8000, 32'h400, 0, 5'h0, 32'h0);
        idle(4);
        // syscall, trap during flush ignored, trap on first idle cycle taken
        cyc(0, 1, 32'h200, 0, 5'b00001, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h204, 0, 5'b00100, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
        cyc(0, 1, 32'h208, 0, 5'b00100, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
        idle(4);
        // EXL masks interrupt; invalid slot masks everything
        cyc(0, 1, 32'h300, 0, 5'h0, 32'h0000_FF03, 32'h0000_FF00, 32'h0, 0, 5'h0, 32'h0);
        cyc(0, 0, 32'h304, 0, 5'h1, 32'h0000_FF01, 32'h0000_FF00, 32'h0, 0, 5'h0, 32'h0);
        // same-cycle Status writes: set EXL, and enable IE
        cyc(0, 1, 32'h308, 0, 5'h0, 32'h0000_FF01, 32'h0000_FF00, 32'h0, 1, 5'd12, 32'h0000_FF03);
        idle(4);
        cyc(0, 1, 32'h30C, 0, 5'h0, 32'h0000_FF00, 32'h0000_FF00, 32'h0, 1, 5'd12, 32'h0000_FF01);
        idle(4);
        // Cause[9:8] write raising a software interrupt
        cyc(0, 1, 32'h310, 0, 5'h0, 32'h0000_0101, 32'h0, 32'h0, 1, 5'd13, 32'h0000_0100);
        idle(4);
        // reset during the second flush cycle, then a clean syscall
        cyc(0, 1, 32'h400, 0, 5'b00001, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
        idle(1);
        cyc(1, 0, 32'h0, 0, 5'h0, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
        idle(1);
        cyc(0, 1, 32'h404, 0, 5'b00001, 32'h0, 32'h0, 32'h0, 0, 5'h0, 32'h0);
        idle(4);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 3));
            case (k)
                0: s = 32'h0000_FF01;
                1: s = 32'h0000_FF03;
                2: s = 32'h0;
                default: s = $urandom;
            endcase
            c = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
            fl = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h0;
            k = int'($urandom_range(0, 3));
            wa = (k == 3) ? 5'($urandom) : 5'(12 + k);
            pc = $urandom;
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, pc, 1'($urandom),
                fl, s, c, $urandom, $urandom_range(0, 2) == 0, wa, $urandom);
        end
        idle(2);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0 || n_pop != n_push) begin
            n_fail++;
            $display("FAIL drain: popped %0d expected %0d", n_pop, n_push);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
